// File: rtl/icetap_capture_ctrl_if.sv
// Probe/trigger/control inputs and capture-RAM write port of the
// ICE-tap capture controller.
interface icetap_capture_ctrl_if #(
  parameter int NR_SIGNALS = 16,
  parameter int ADDR_BITS  = 8
);
  logic [NR_SIGNALS-1:0] signals_in;
  logic                  sample_en;
  logic                  arm;
  logic                  abort;
  logic                  force_trigger;
  logic [NR_SIGNALS-1:0] trigger_mask;
  logic [NR_SIGNALS-1:0] trigger_value;
  logic [ADDR_BITS-1:0]  pre_count;
  logic [ADDR_BITS-1:0]  post_count;
  logic                  ram_wr_en;
  logic [ADDR_BITS-1:0]  ram_wr_addr;
  logic [NR_SIGNALS-1:0] ram_wr_data;
  logic [ADDR_BITS-1:0]  trigger_addr;
  logic                  busy;
  logic                  done;
  logic [2:0]            state;

  modport master (
    output signals_in, sample_en, arm, abort, force_trigger,
           trigger_mask, trigger_value, pre_count, post_count,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, trigger_addr, busy, done, state
  );
  modport slave (
    input  signals_in, sample_en, arm, abort, force_trigger,
           trigger_mask, trigger_value, pre_count, post_count,
    output ram_wr_en, ram_wr_addr, ram_wr_data, trigger_addr, busy, done, state
  );
endinterface

// File: rtl/icetap_capture_ctrl.sv
// Logic-analyser capture controller: fills a circular RAM with pre-trigger
// history, waits for a masked compare match, then records post-trigger samples.
module icetap_capture_ctrl #(
  parameter int NR_SIGNALS   = 16,
  parameter int RECORD_DEPTH = 256,
  parameter int ADDR_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  icetap_capture_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               r_state, w_next;
  logic [ADDR_BITS-1:0] r_wr_addr, r_cnt, r_pre, r_post, r_trig_addr;
  logic [ADDR_BITS-1:0] w_cnt_nxt;
  logic                 w_busy, w_wr, w_match, w_arm_ok;

  assign w_busy    = (r_state == PRE) || (r_state == ARMED) || (r_state == POST);
  assign w_wr      = bus.sample_en && w_busy && !bus.abort;
  assign w_match   = (r_state == ARMED) && bus.sample_en &&
                     (bus.force_trigger ||
                      (((bus.signals_in ^ bus.trigger_value) & bus.trigger_mask) == '0));
  assign w_arm_ok  = bus.arm && ((r_state == IDLE) || (r_state == DONE));
  assign w_cnt_nxt = r_cnt + 1'b1;

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (bus.arm) w_next = PRE;
        // pre_count of zero skips history collection after a single cycle
        PRE:   if (r_pre == '0 || (w_wr && w_cnt_nxt == r_pre)) w_next = ARMED;
        ARMED: if (w_match) w_next = (r_post == '0) ? DONE : POST;
        POST:  if (w_wr && w_cnt_nxt == r_post) w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_addr   <= '0;
      r_cnt       <= '0;
      r_pre       <= '0;
      r_post      <= '0;
      r_trig_addr <= '0;
    end else begin
      r_state <= w_next;
      if (!bus.abort) begin
        if (w_arm_ok) begin
          r_pre     <= bus.pre_count;
          r_post    <= bus.post_count;
          r_wr_addr <= '0;
          r_cnt     <= '0;
        end else if (w_wr) begin
          // address width equals log2(depth), so the increment wraps naturally
          r_wr_addr <= r_wr_addr + 1'b1;
          if (r_state == ARMED) begin
            if (w_match) begin
              r_trig_addr <= r_wr_addr;
              r_cnt       <= '0;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
      end
    end
  end

  assign bus.ram_wr_en    = w_wr;
  assign bus.ram_wr_addr  = r_wr_addr;
  assign bus.ram_wr_data  = bus.signals_in;
  assign bus.trigger_addr = r_trig_addr;
  assign bus.busy         = w_busy;
  assign bus.done         = (r_state == DONE);
  assign bus.state        = r_state;
endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Bench for icetap_capture_ctrl: per-cycle vector table, directed corner
// sequences and random captures checked against a sample-stream model.
module tb_icetap_capture_ctrl;
  localparam int NS = 16;
  localparam int AB = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  icetap_capture_ctrl_if #(.NR_SIGNALS(NS), .ADDR_BITS(AB)) bus ();

  icetap_capture_ctrl #(.NR_SIGNALS(NS), .RECORD_DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AB-1:0] a;
    logic [NS-1:0] d;
  } wr_t;

  wr_t      got_q[$];
  bit       rec = 1'b0;
  bit       st_en[0:511];
  logic [NS-1:0] st_d[0:511];

  always @(negedge clk) if (rec && bus.ram_wr_en) got_q.push_back('{bus.ram_wr_addr, bus.ram_wr_data});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.signals_in = '0; bus.sample_en = 0; bus.arm = 0; bus.abort = 0;
    bus.force_trigger = 0; bus.trigger_mask = '0; bus.trigger_value = '0;
    bus.pre_count = '0; bus.post_count = '0;
  endtask

  task automatic start_capture(input logic [AB-1:0] pre, input logic [AB-1:0] post,
                               input logic [NS-1:0] mask, input logic [NS-1:0] val);
    bus.abort = 1; bus.sample_en = 0;
    step();
    bus.abort = 0; bus.arm = 1;
    bus.pre_count = pre; bus.post_count = post;
    bus.trigger_mask = mask; bus.trigger_value = val;
    step();
    bus.arm = 0;
  endtask

  // Expected capture derived from the qualified sample stream: sample k lands
  // at k mod DEPTH, compare starts at sample index pre, ends post samples later.
  task automatic run_capture(input string tag, input logic [AB-1:0] pre, input logic [AB-1:0] post,
                             input logic [NS-1:0] mask, input logic [NS-1:0] val, input int n);
    wr_t exp_q[$];
    int  k = 0;
    int  trig = -1;
    bit  fin = 0;
    for (int c = 0; c < n; c++) begin
      if (st_en[c] && !fin) begin
        exp_q.push_back('{AB'(k % DEPTH), st_d[c]});
        if (trig < 0 && k >= pre && ((st_d[c] ^ val) & mask) == '0) trig = k;
        if (trig >= 0 && k == trig + post) fin = 1;
        k++;
      end
    end
    start_capture(pre, post, mask, val);
    got_q.delete();
    rec = 1;
    for (int c = 0; c < n; c++) begin
      bus.sample_en = st_en[c];
      bus.signals_in = st_d[c];
      step();
    end
    bus.sample_en = 0;
    rec = 0;
    chk({tag, " nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d) begin
        chk({tag, " write"}, {got_q[i].a, got_q[i].d}, {exp_q[i].a, exp_q[i].d});
      end else begin
        n_vec++;
      end
    end
    if (fin) begin
      chk({tag, " done"}, bus.done, 1);
      chk({tag, " trig_addr"}, bus.trigger_addr, trig % DEPTH);
    end else begin
      chk({tag, " busy"}, bus.busy, 1);
    end
  endtask

  typedef struct {
    logic          arm, abort, en;
    logic [NS-1:0] sig;
    logic [AB-1:0] pre, post;
    logic [NS-1:0] mask, val;
    logic [2:0]    e_state;
    logic          e_wren;
    logic [AB-1:0] e_addr, e_trig;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // arm/abort/en/sig/pre/post/mask/val -> state/wren/addr/trig
    tbl[0]  = '{1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'd0, 0, 8'd0, 8'd0};
    tbl[1]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'd1, 0, 8'd0, 8'd0};
    tbl[2]  = '{0, 0, 1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 3'd2, 1, 8'd0, 8'd0};
    tbl[3]  = '{0, 0, 1, 16'h0006, 0, 0, 16'h0000, 16'h0000, 3'd4, 0, 8'd1, 8'd0};
    tbl[4]  = '{1, 0, 0, 16'h0000, 1, 2, 16'hFFFF, 16'hAAAA, 3'd4, 0, 8'd1, 8'd0};
    tbl[5]  = '{0, 0, 1, 16'h1234, 1, 2, 16'hFFFF, 16'hAAAA, 3'd1, 1, 8'd0, 8'd0};
    tbl[6]  = '{1, 0, 1, 16'h0000, 1, 2, 16'hFFFF, 16'hAAAA, 3'd2, 1, 8'd1, 8'd0};
    tbl[7]  = '{0, 0, 0, 16'h0000, 1, 2, 16'hFFFF, 16'hAAAA, 3'd2, 0, 8'd2, 8'd0};
    tbl[8]  = '{0, 0, 1, 16'hAAAA, 1, 2, 16'hFFFF, 16'hAAAA, 3'd2, 1, 8'd2, 8'd0};
    tbl[9]  = '{0, 0, 1, 16'h0000, 1, 2, 16'hFFFF, 16'hAAAA, 3'd3, 1, 8'd3, 8'd2};
    tbl[10] = '{0, 1, 1, 16'h0000, 1, 2, 16'hFFFF, 16'hAAAA, 3'd3, 0, 8'd4, 8'd2};
    tbl[11] = '{0, 0, 1, 16'h0000, 1, 2, 16'hFFFF, 16'hAAAA, 3'd0, 0, 8'd4, 8'd2};

    idle_inputs();
    reset = 1;
    bus.sample_en = 1;
    #3;
    chk("rst state", bus.state, 0);
    chk("rst wren", bus.ram_wr_en, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst trig", bus.trigger_addr, 0);
    chk("rst addr", bus.ram_wr_addr, 0);
    step();
    reset = 0;
    bus.sample_en = 0;
    step();

    for (int i = 0; i < 12; i++) begin
      bus.arm = tbl[i].arm; bus.abort = tbl[i].abort; bus.sample_en = tbl[i].en;
      bus.signals_in = tbl[i].sig; bus.pre_count = tbl[i].pre; bus.post_count = tbl[i].post;
      bus.trigger_mask = tbl[i].mask; bus.trigger_value = tbl[i].val;
      @(negedge clk);
      chk($sformatf("tbl%0d state", i), bus.state, tbl[i].e_state);
      chk($sformatf("tbl%0d wren", i), bus.ram_wr_en, tbl[i].e_wren);
      chk($sformatf("tbl%0d addr", i), bus.ram_wr_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d trig", i), bus.trigger_addr, tbl[i].e_trig);
      chk($sformatf("tbl%0d done", i), bus.done, tbl[i].e_state == 3'd4);
      chk($sformatf("tbl%0d busy", i), bus.busy, tbl[i].e_state inside {3'd1, 3'd2, 3'd3});
      step();
    end
    idle_inputs();

    // reset between edges while collecting pre-trigger history
    start_capture(8'd10, 8'd1, 16'hFFFF, 16'h0000);
    bus.sample_en = 1;
    bus.signals_in = 16'h00F0;
    step();
    chk("midpre state", bus.state, 1);
    #2;
    reset = 1;
    #1;
    chk("async state", bus.state, 0);
    chk("async wren", bus.ram_wr_en, 0);
    chk("async busy", bus.busy, 0);
    chk("async addr", bus.ram_wr_addr, 0);
    step();
    reset = 0;
    bus.sample_en = 0;
    step();

    // bit0 rises on the 10th sample
    for (int c = 0; c < 20; c++) begin
      st_en[c] = 1;
      st_d[c] = (c >= 9) ? 16'h0001 : 16'h0000;
    end
    run_capture("pre4post3", 8'd4, 8'd3, 16'h0001, 16'h0001, 20);
    chk("pre4post3 trig9", bus.trigger_addr, 9);

    // wrap with no match, then force
    start_capture(8'd2, 8'd1, 16'hFFFF, 16'hFFFF);
    for (int c = 0; c < 300; c++) begin
      bus.sample_en = 1;
      bus.signals_in = NS'(c);
      if (c == 255) chk("wrap addr255", bus.ram_wr_addr, 255);
      if (c == 256) chk("wrap addr0", bus.ram_wr_addr, 0);
      step();
    end
    bus.sample_en = 0;
    chk("wrap state", bus.state, 2);
    chk("wrap busy", bus.busy, 1);
    chk("wrap addr44", bus.ram_wr_addr, 44);
    bus.sample_en = 1;
    bus.force_trigger = 1;
    step();
    bus.sample_en = 0;
    bus.force_trigger = 0;
    chk("force trig", bus.trigger_addr, 44);
    chk("force state", bus.state, 3);

    for (int r = 0; r < 8; r++) begin
      logic [NS-1:0] m, v;
      m = (NS'(1) << $urandom_range(0, NS-1)) | (NS'(1) << $urandom_range(0, NS-1));
      v = NS'($urandom);
      for (int c = 0; c < 150; c++) begin
        st_en[c] = ($urandom_range(0, 3) != 0);
        st_d[c] = NS'($urandom);
      end
      run_capture($sformatf("rnd%0d", r), AB'($urandom_range(1, 20)), AB'($urandom_range(0, 20)), m, v, 150);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/icetap_capture_ctrl.md
ICETAP_CAPTURE_CTRL -- requirements
Module: icetap_capture_ctrl

Interface
REQ-001 SHALL have parameter NR_SIGNALS, default 16: width of the sampled signal bus.
REQ-002 SHALL have parameter RECORD_DEPTH, default 256: capture RAM depth, power of two.
REQ-003 SHALL have parameter ADDR_BITS, default 8: equal to log2(RECORD_DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port signals_in, input, NR_SIGNALS bits: sampled probe signals.
REQ-007 SHALL have port sample_en, input, 1 bit: qualifies signals_in as a valid sample this cycle.
REQ-008 SHALL have port arm, input, 1 bit: single-cycle request to start a capture.
REQ-009 SHALL have port abort, input, 1 bit: cancels any capture.
REQ-010 SHALL have port force_trigger, input, 1 bit: unconditional trigger while ARMED.
REQ-011 SHALL have port trigger_mask, input, NR_SIGNALS bits: 1 = bit participates in the compare.
REQ-012 SHALL have port trigger_value, input, NR_SIGNALS bits: compare value.
REQ-013 SHALL have port pre_count, input, ADDR_BITS bits: number of pre-trigger samples.
REQ-014 SHALL have port post_count, input, ADDR_BITS bits: number of post-trigger samples.
REQ-015 SHALL have port ram_wr_en, output, 1 bit: capture RAM write strobe.
REQ-016 SHALL have port ram_wr_addr, output, ADDR_BITS bits: capture RAM write address.
REQ-017 SHALL have port ram_wr_data, output, NR_SIGNALS bits: capture RAM write data.
REQ-018 SHALL have port trigger_addr, output, ADDR_BITS bits: RAM address of the trigger sample.
REQ-019 SHALL have port busy, output, 1 bit: high in state PRE, ARMED or POST.
REQ-020 SHALL have port done, output, 1 bit: high in state DONE.
REQ-021 SHALL have port state, output, 3 bits: current state; IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4.

Function
REQ-022 SHALL have the FSM states IDLE, PRE, ARMED, POST and DONE.
REQ-023 SHALL treat arm in IDLE or DONE as follows: pre_count and post_count latched, write address cleared to 0, sample counter cleared, next state PRE; arm SHALL be ignored in PRE, ARMED and POST.
REQ-024 SHALL generate writes combinationally: ram_wr_en = sample_en AND state in {PRE, ARMED, POST}; ram_wr_data = signals_in; ram_wr_addr = the write address register.
REQ-025 SHALL increment the write address by 1 after every write, wrapping from RECORD_DEPTH-1 to 0.
REQ-026 SHALL, in PRE, count writes and enter ARMED on the write that makes the count equal to the latched pre_count; with latched pre_count=0, PRE SHALL go to ARMED after one cycle with no compare.
REQ-027 SHALL evaluate the trigger only in ARMED, using match = sample_en AND (force_trigger OR ((signals_in XOR trigger_value) AND trigger_mask)==0); mask and value are not latched.
REQ-028 SHALL, on a match, write the trigger sample, set trigger_addr to that sample's address, clear the sample counter, and move to POST, or directly to DONE when the latched post_count=0.
REQ-029 SHALL, in POST, move to DONE on the write that makes the post-trigger count equal to the latched post_count.
REQ-030 SHALL treat an all-zero trigger_mask as matching on the first qualified sample in ARMED.
REQ-031 SHALL hold the sample counter and address in any busy-state cycle with sample_en=0.
REQ-032 SHALL give abort the highest priority in any state: next state IDLE, ram_wr_en forced 0 that cycle, arm and match ignored, trigger_addr unchanged.
REQ-033 SHALL hold trigger_addr stable in DONE until the next accepted arm; arm SHALL NOT clear it.
REQ-034 SHALL leave correct capture ordering to software, which keeps pre_count+post_count+1 <= RECORD_DEPTH; larger values SHALL still run, with oldest samples overwritten by wrap.

Reset
REQ-035 SHALL, while reset=1 (asynchronous assertion), force: state=IDLE, write address=0, counters=0, latched counts=0, trigger_addr=0, busy=0, done=0, ram_wr_en=0.
REQ-036 SHALL, on reset mid-capture, abandon the capture with no further writes, and start operating on the first clk edge after reset deasserts.

Verification
REQ-037 SHALL pass: pre=4, post=3, mask=0x0001, value=0x0001, bit0 rising at the 10th sample -> writes at addr 0..12, trigger_addr=9, done after the write to addr 12.
REQ-038 SHALL pass: pre=0, post=0, mask=0 -> PRE for 1 cycle, exactly one write (addr 0) in ARMED, trigger_addr=0, DONE next cycle.
REQ-039 SHALL pass: pre=2, no match for 300 samples -> address wraps 255->0, stays ARMED, busy=1; force_trigger then gives trigger_addr=(300 mod 256)=44.
REQ-040 SHALL pass: abort asserted in POST together with sample_en -> no write that cycle, IDLE next cycle, trigger_addr keeps its value, done=0.
REQ-041 SHALL pass: arm pulsed while ARMED -> ignored, address not cleared; arm in DONE -> restarts at addr 0.
REQ-042 SHALL pass: reset asserted mid-PRE between clock edges -> outputs at reset values immediately, with no clk edge needed.
